mult_div_seq: RTL
=================

Name: mult_div_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair for mult, multu, div, divu, mthi and mtlo. It sits beside the ula in the execute stage. It takes the same rs/rt operands (In1, In2), runs a radix-2 shift-add multiply or restoring divide over 32 iterations, and raises busy so the control unit can stall. hi/lo feed the mfhi/mflo writeback mux.

Parameters:
WIDTH, 32, operand width; hi and lo are WIDTH bits each; iteration count equals WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a mult/div; sampled only in IDLE
OP  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
In1  input  WIDTH  rs: multiplicand or dividend
In2  input  WIDTH  rt: multiplier or divisor
write_hi  input  1  mthi strobe
write_lo  input  1  mtlo strobe
wdata  input  WIDTH  data for mthi/mtlo
busy  output  1  operation in progress; control unit stalls mfhi/mflo/start on it
done  output  1  one-cycle pulse when a new hi/lo result is visible
div_by_zero  output  1  last accepted div/divu had In2 == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset values, with reset taking priority over all other inputs at every edge: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
- Reset asserted mid-operation aborts the operation; hi/lo return to 0 and no done pulse is produced.
- States:
  - IDLE -> ITER on start.
  - IDLE -> FIN on start with div/divu and In2 == 0.
  - ITER -> FIN after the 32nd iteration.
  - FIN -> IDLE unconditionally.
- busy=1 exactly in ITER and FIN.
- Accept (edge k, state IDLE, start=1):
  - Latch OP and the operand sign bits.
  - Latch magnitudes: two's-complement absolute value for mult/div, raw value for multu/divu.
  - counter=0; div_by_zero cleared.
- ITER, one iteration per edge at edges k+1..k+32:
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator; shift the 64-bit {acc, multiplier} right by 1 with carry-in.
  - Divide: shift {rem, quot} left by 1; if rem >= divisor, subtract and set the quot LSB.
  - counter increments; at counter == 31 the next state is FIN.
- FIN, edge k+33:
  - Apply sign correction and write hi/lo; state returns to IDLE.
  - done=1 and busy=0 during cycle k+33. Total latency from start to result is 33 edges.
- Sign rules:
  - mult: negate the 64-bit product when the operand signs differ; {hi, lo} = product.
  - div: quotient -> lo, remainder -> hi. Negate the quotient when the signs differ. The remainder takes the sign of the dividend.
  - multu/divu: no correction.
  - Boundary: 0x80000000 / 0xFFFFFFFF (div) gives lo=0x80000000, hi=0.
- Divide by zero (div/divu, In2 == 0):
  - Accept goes directly to FIN with no iterations; hi/lo are left unchanged.
  - div_by_zero=1 from edge k+1; done pulses in cycle k+1.
  - The flag holds until the next accepted start.
- start while busy is ignored; the operands and OP are not latched.
- mthi/mtlo:
  - In IDLE only, write_hi/write_lo load wdata into hi/lo at the next edge. Both may be asserted together.
  - No done pulse; div_by_zero is unaffected.
  - Strobes are ignored while busy.
  - If start and a write strobe are asserted in the same IDLE cycle, start wins and the write is dropped.
- done is never asserted in two consecutive cycles.

Test Plan:
1. mult, In1=0xFFFFFFFD (-3), In2=5 -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 33 cycles.
2. multu, In1=In2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then mult with the same operands -> hi=0, lo=1.
3. div, In1=0xFFFFFFF9 (-7), In2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. After mthi 0x1234 and mtlo 0x5678: divu with In2=0 -> done one cycle after start, div_by_zero=1, hi=0x1234, lo=0x5678. A following multu 2*3 clears the flag; lo=6.
5. Start a mult 2*3, then at cycle 10 assert start (divu 9/3) plus write_lo=1 with wdata=0xAAAA -> both ignored; result is lo=6, hi=0. Start and write_hi in the same IDLE cycle -> write dropped.
6. Assert reset at cycle 15 of a div -> next cycle busy=0, hi=lo=0, no done. A fresh multu 7*6 afterwards -> lo=42.

Source files
------------

// File: rtl/mult_div_seq.sv
`default_nettype none
// ============================================================================
// mult_div_seq : iterative radix-2 multiply / restoring divide owning HI/LO
// Revision     : 1.0
// ============================================================================
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [1:0] C_OP_MULT  = 2'b00;
  localparam logic [1:0] C_OP_MULTU = 2'b01;
  localparam logic [1:0] C_OP_DIV   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // multiply upper accumulator / divide remainder
  logic [WIDTH-1:0] work_q, work_d;   // multiplier / quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             is_signed;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    is_signed = ~OP[0];
    sum       = '0;
    rem_sh    = '0;
    prod      = {acc_q, work_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = OP;
          sign1_d = In1[WIDTH-1];
          sign2_d = In2[WIDTH-1];
          acc_d   = '0;
          work_d  = (is_signed && In1[WIDTH-1]) ? -In1 : In1;
          opnd_d  = (is_signed && In2[WIDTH-1]) ? -In2 : In2;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = (OP[1] && (In2 == '0)) ? FIN : ITER;
        end else begin
          if (write_hi) hi_d = wdata;
          if (write_lo) lo_d = wdata;
        end
      end

      ITER: begin
        if (!op_q[1]) begin
          sum    = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
          acc_d  = sum[WIDTH:1];
          work_d = {sum[0], work_q[WIDTH-1:1]};
        end else begin
          // Remainder can momentarily need WIDTH+1 bits before the subtract.
          rem_sh = {acc_q, work_q[WIDTH-1]};
          if (rem_sh >= {1'b0, opnd_q}) begin
            acc_d  = rem_sh[WIDTH-1:0] - opnd_q;
            work_d = {work_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = rem_sh[WIDTH-1:0];
            work_d = {work_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_CNT) state_d = FIN;
      end

      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q[1] && (opnd_q == '0)) begin
          dbz_d = 1'b1;
        end else if (op_q == C_OP_MULT) begin
          if (sign1_q ^ sign2_q) prod = -prod;
          {hi_d, lo_d} = prod;
        end else if (op_q == C_OP_MULTU) begin
          {hi_d, lo_d} = {acc_q, work_q};
        end else if (op_q == C_OP_DIV) begin
          lo_d = (sign1_q ^ sign2_q) ? -work_q : work_q;
          hi_d = sign1_q ? -acc_q : acc_q;
        end else begin
          lo_d = work_q;
          hi_d = acc_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      acc_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      acc_q   <= acc_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire
